// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the per-axis phase encoding.
// The per-axis successor function is kept here as well.
package vga_timing_pkg;

  localparam int CNT_W = 16;
  localparam int PIX_W = 10;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  function automatic phase_e next_phase(input phase_e ph);
    phase_e nxt;
    case (ph)
      PH_ACTIVE: nxt = PH_FRONT;
      PH_FRONT:  nxt = PH_SYNC;
      PH_SYNC:   nxt = PH_BACK;
      PH_BACK:   nxt = PH_ACTIVE;
      default:   nxt = PH_BACK;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vga_axis_phase.sv
// One axis of the sync generator: phase FSM plus count-continuity and range check.
// phase_nxt and fault are combinational; the top registers everything it drives out.
module vga_axis_phase
  import vga_timing_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int VISIBLE = 640,
  parameter int FP      = 16,
  parameter int SYNC_W  = 96,
  parameter int BP      = 48
) (
  input  logic             clk_25MHz,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] count,
  input  logic             advance,
  input  logic             first_sample,
  output logic [1:0]       phase_nxt,
  output logic             fault,
  output logic             out_of_range
);

  localparam logic [CNT_W-1:0] B_FRONT = CNT_W'(VISIBLE);
  localparam logic [CNT_W-1:0] B_SYNC  = CNT_W'(VISIBLE + FP);
  localparam logic [CNT_W-1:0] B_BACK  = CNT_W'(VISIBLE + FP + SYNC_W);
  localparam logic [CNT_W-1:0] B_LAST  = CNT_W'(VISIBLE + FP + SYNC_W + BP - 1);

  phase_e           phase_r;
  phase_e           nxt_s;
  phase_e           dec_s;
  logic [CNT_W-1:0] prev_r;
  logic [CNT_W-1:0] exp_s;
  logic [CNT_W-1:0] boundary_s;
  logic             jump_s;
  logic             oor_s;

  // Phase decode, continuity check and next-state selection
  always_comb begin
    dec_s      = PH_BACK;
    exp_s      = prev_r;
    boundary_s = {CNT_W{1'b0}};
    nxt_s      = phase_r;

    if (count < B_FRONT) begin
      dec_s = PH_ACTIVE;
    end else if (count < B_SYNC) begin
      dec_s = PH_FRONT;
    end else if (count < B_BACK) begin
      dec_s = PH_SYNC;
    end else begin
      dec_s = PH_BACK;
    end

    if (!advance) begin
      exp_s = prev_r;
    end else if (prev_r == B_LAST) begin
      exp_s = {CNT_W{1'b0}};
    end else begin
      exp_s = prev_r + CNT_W'(1);
    end

    oor_s  = (count > B_LAST);
    jump_s = !first_sample && (count != exp_s);

    case (phase_r)
      PH_ACTIVE: boundary_s = B_FRONT;
      PH_FRONT:  boundary_s = B_SYNC;
      PH_SYNC:   boundary_s = B_BACK;
      PH_BACK:   boundary_s = {CNT_W{1'b0}};
      default:   boundary_s = {CNT_W{1'b0}};
    endcase

    // Any doubt about the count history: trust the count itself.
    if (first_sample || jump_s || oor_s) begin
      nxt_s = dec_s;
    end else if (count == boundary_s) begin
      nxt_s = next_phase(phase_r);
    end else begin
      nxt_s = phase_r;
    end
  end

  assign phase_nxt    = nxt_s;
  assign fault        = oor_s | jump_s;
  assign out_of_range = oor_s;

  // Phase state and previous-count registers
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      phase_r <= PH_BACK;
      prev_r  <= {CNT_W{1'b0}};
    end else begin
      phase_r <= nxt_s;
      prev_r  <= count;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator driven by external H/V counts: registered syncs, blanking,
// pixel coordinates, line/frame pulses, frame counter and a sticky timing fault.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input  logic        clk_25MHz,
  input  logic        reset_n,
  input  logic        enable_V_counter,
  input  logic [15:0] H_Count_Value,
  input  logic [15:0] V_Count_Value,
  output logic        Hsync,
  output logic        Vsync,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count,
  output logic        timing_error
);

  logic       first_r;
  logic       en_v_r;
  logic [1:0] h_ph_s;
  logic [1:0] v_ph_s;
  logic       h_fault_s;
  logic       v_fault_s;
  logic       h_oor_s;
  logic       v_oor_s;

  logic             hsync_s, vsync_s, video_s, line_s, frame_s;
  logic [PIX_W-1:0] px_s, py_s;

  logic             hsync_r, vsync_r, video_r, line_r, frame_r, err_r;
  logic [PIX_W-1:0] px_r, py_r;
  logic [15:0]      frame_cnt_r;

  vga_axis_phase #(
    .CNT_W(CNT_W), .VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC_W(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk_25MHz   (clk_25MHz),
    .reset_n     (reset_n),
    .count       (H_Count_Value),
    .advance     (1'b1),
    .first_sample(first_r),
    .phase_nxt   (h_ph_s),
    .fault       (h_fault_s),
    .out_of_range(h_oor_s)
  );

  // V may only step in the sample after the end-of-line pulse was seen.
  vga_axis_phase #(
    .CNT_W(CNT_W), .VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC_W(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk_25MHz   (clk_25MHz),
    .reset_n     (reset_n),
    .count       (V_Count_Value),
    .advance     (en_v_r),
    .first_sample(first_r),
    .phase_nxt   (v_ph_s),
    .fault       (v_fault_s),
    .out_of_range(v_oor_s)
  );

  // Next output values from the phases the axes are entering
  always_comb begin
    hsync_s = 1'b1;
    vsync_s = 1'b1;
    video_s = 1'b0;
    line_s  = 1'b0;
    px_s    = {PIX_W{1'b0}};
    py_s    = {PIX_W{1'b0}};

    if (h_oor_s || v_oor_s) begin
      hsync_s = 1'b1;
      vsync_s = 1'b1;
      video_s = 1'b0;
      line_s  = 1'b0;
    end else begin
      hsync_s = (h_ph_s != PH_SYNC);
      vsync_s = (v_ph_s != PH_SYNC);
      video_s = (h_ph_s == PH_ACTIVE) && (v_ph_s == PH_ACTIVE);
      line_s  = (H_Count_Value == 16'd0);
    end

    frame_s = line_s && (V_Count_Value == 16'd0);

    if (video_s) begin
      px_s = H_Count_Value[PIX_W-1:0];
      py_s = V_Count_Value[PIX_W-1:0];
    end else begin
      px_s = {PIX_W{1'b0}};
      py_s = {PIX_W{1'b0}};
    end
  end

  // Output registers, sticky fault and frame counter
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      first_r     <= 1'b1;
      en_v_r      <= 1'b0;
      hsync_r     <= 1'b1;
      vsync_r     <= 1'b1;
      video_r     <= 1'b0;
      px_r        <= {PIX_W{1'b0}};
      py_r        <= {PIX_W{1'b0}};
      line_r      <= 1'b0;
      frame_r     <= 1'b0;
      frame_cnt_r <= 16'd0;
      err_r       <= 1'b0;
    end else begin
      first_r <= 1'b0;
      en_v_r  <= enable_V_counter;
      hsync_r <= hsync_s;
      vsync_r <= vsync_s;
      video_r <= video_s;
      px_r    <= px_s;
      py_r    <= py_s;
      line_r  <= line_s;
      frame_r <= frame_s;
      if (frame_s) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
      err_r <= err_r | h_fault_s | v_fault_s;
    end
  end

  assign Hsync        = hsync_r;
  assign Vsync        = vsync_r;
  assign video_on     = video_r;
  assign pixel_x      = px_r;
  assign pixel_y      = py_r;
  assign line_start   = line_r;
  assign frame_start  = frame_r;
  assign frame_count  = frame_cnt_r;
  assign timing_error = err_r;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: hand-computed vector table, scoreboard against a
// count-decoding reference model, and a reduced-geometry instance for a full frame.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  logic        clk_25MHz = 1'b0;
  logic        reset_n;
  logic        enable_V_counter;
  logic [15:0] H_Count_Value, V_Count_Value;
  logic        Hsync, Vsync, video_on, line_start, frame_start, timing_error;
  logic [9:0]  pixel_x, pixel_y;
  logic [15:0] frame_count;

  logic        m_rst_n, m_en;
  logic [15:0] m_h, m_v;
  logic        m_hsync, m_vsync, m_video, m_ls, m_fs, m_err;
  logic [9:0]  m_px, m_py;
  logic [15:0] m_fcnt;

  int n_checks = 0;
  int n_errors = 0;

  always #20 clk_25MHz = ~clk_25MHz;

  vga_sync_gen u_dut (
    .clk_25MHz(clk_25MHz), .reset_n(reset_n), .enable_V_counter(enable_V_counter),
    .H_Count_Value(H_Count_Value), .V_Count_Value(V_Count_Value),
    .Hsync(Hsync), .Vsync(Vsync), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .line_start(line_start), .frame_start(frame_start),
    .frame_count(frame_count), .timing_error(timing_error)
  );

  // 25x12 frame: H sync at 18..21, V sync at lines 8..9, 16x6 visible
  vga_sync_gen #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VISIBLE(6),  .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) u_mini (
    .clk_25MHz(clk_25MHz), .reset_n(m_rst_n), .enable_V_counter(m_en),
    .H_Count_Value(m_h), .V_Count_Value(m_v),
    .Hsync(m_hsync), .Vsync(m_vsync), .video_on(m_video),
    .pixel_x(m_px), .pixel_y(m_py),
    .line_start(m_ls), .frame_start(m_fs),
    .frame_count(m_fcnt), .timing_error(m_err)
  );

  typedef struct {
    logic        hs, vs, vid;
    logic [9:0]  px, py;
    logic        ls, fs;
    logic [15:0] fc;
    logic        err;
  } exp_t;

  typedef struct {
    logic        rst;
    logic [15:0] h, v;
    logic        en;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  vec_t tab[$];

  logic [15:0] r_prev_h, r_prev_v, r_fc;
  logic        r_en, r_first, r_err;

  function automatic exp_t mk(input logic hs, vs, vid, input int px, py,
                              input logic ls, fs, input int fc, input logic err);
    exp_t e;
    e.hs = hs; e.vs = vs; e.vid = vid;
    e.px = 10'(px); e.py = 10'(py);
    e.ls = ls; e.fs = fs; e.fc = 16'(fc); e.err = err;
    return e;
  endfunction

  function automatic vec_t row(input logic rst, input int h, v, input logic en, input exp_t e);
    vec_t r;
    r.rst = rst; r.h = 16'(h); r.v = 16'(v); r.en = en; r.e = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    r_prev_h = 16'd0; r_prev_v = 16'd0; r_fc = 16'd0;
    r_en = 1'b0; r_first = 1'b1; r_err = 1'b0;
  endtask

  // Reference: outputs follow straight from the sampled counts (default 640x480 timing)
  task automatic model(input logic [15:0] h, v, input logic en, output exp_t e);
    logic        oor, bad;
    logic [15:0] eh, ev;
    oor = (h > 16'd799) || (v > 16'd524);
    eh  = (r_prev_h == 16'd799) ? 16'd0 : r_prev_h + 16'd1;
    ev  = !r_en ? r_prev_v : ((r_prev_v == 16'd524) ? 16'd0 : r_prev_v + 16'd1);
    bad = !r_first && ((h != eh) || (v != ev));
    r_err = r_err | oor | bad;
    e.vid = !oor && (h < 16'd640) && (v < 16'd480);
    e.hs  = oor || !((h >= 16'd656) && (h < 16'd752));
    e.vs  = oor || !((v >= 16'd490) && (v < 16'd492));
    e.ls  = !oor && (h == 16'd0);
    e.fs  = e.ls && (v == 16'd0);
    if (e.fs) r_fc = r_fc + 16'd1;
    e.fc  = r_fc;
    e.err = r_err;
    e.px  = e.vid ? h[9:0] : 10'd0;
    e.py  = e.vid ? v[9:0] : 10'd0;
    r_prev_h = h; r_prev_v = v; r_en = en; r_first = 1'b0;
  endtask

  task automatic check_dut();
    exp_t e;
    e = sb_q.pop_front();
    chk("hsync",       16'(Hsync),        16'(e.hs));
    chk("vsync",       16'(Vsync),        16'(e.vs));
    chk("video_on",    16'(video_on),     16'(e.vid));
    chk("pixel_x",     16'(pixel_x),      16'(e.px));
    chk("pixel_y",     16'(pixel_y),      16'(e.py));
    chk("line_start",  16'(line_start),   16'(e.ls));
    chk("frame_start", 16'(frame_start),  16'(e.fs));
    chk("frame_count", frame_count,       e.fc);
    chk("timing_err",  16'(timing_error), 16'(e.err));
  endtask

  task automatic drive(input logic [15:0] h, v, input logic en, input exp_t e);
    H_Count_Value = h; V_Count_Value = v; enable_V_counter = en;
    sb_q.push_back(e);
    @(posedge clk_25MHz); #1;
    check_dut();
  endtask

  task automatic drive_model(input logic [15:0] h, v, input logic en);
    exp_t e;
    model(h, v, en, e);
    drive(h, v, en, e);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    H_Count_Value = 16'd0; V_Count_Value = 16'd0; enable_V_counter = 1'b0;
    @(posedge clk_25MHz); @(posedge clk_25MHz); #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic run_lines(input int v0, input int n, output int hs_lo, output int vs_lo, output int vid);
    hs_lo = 0; vs_lo = 0; vid = 0;
    for (int l = 0; l < n; l++) begin
      for (int h = 0; h < 800; h++) begin
        drive_model(16'(h), 16'(v0 + l), h == 799);
        hs_lo += int'(!Hsync); vs_lo += int'(!Vsync); vid += int'(video_on);
      end
    end
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t junk;
    int   hs_lo, vs_lo, vid, hs2, vs2, vid2, fs_n;

    reset_n = 1'b0; m_rst_n = 1'b0;
    H_Count_Value = 16'd0; V_Count_Value = 16'd0; enable_V_counter = 1'b0;
    m_h = 16'd0; m_v = 16'd0; m_en = 1'b0;
    model_reset();

    // Reset state
    @(posedge clk_25MHz); #1;
    chk("rst_hsync", 16'(Hsync), 16'd1);
    chk("rst_vsync", 16'(Vsync), 16'd1);
    chk("rst_video", 16'(video_on), 16'd0);
    chk("rst_px", 16'(pixel_x), 16'd0);
    chk("rst_py", 16'(pixel_y), 16'd0);
    chk("rst_ls", 16'(line_start), 16'd0);
    chk("rst_fs", 16'(frame_start), 16'd0);
    chk("rst_fc", frame_count, 16'd0);
    chk("rst_err", 16'(timing_error), 16'd0);

    // Full clean frame on the reduced-geometry instance
    m_rst_n = 1'b1;
    hs_lo = 0; vs_lo = 0; vid = 0; fs_n = 0;
    for (int v = 0; v < 12; v++) begin
      for (int h = 0; h < 25; h++) begin
        m_h = 16'(h); m_v = 16'(v); m_en = (h == 24);
        @(posedge clk_25MHz); #1;
        chk("mini_hsync", 16'(m_hsync), 16'(!((h >= 18) && (h < 22))));
        chk("mini_vsync", 16'(m_vsync), 16'(!((v >= 8) && (v < 10))));
        chk("mini_video", 16'(m_video), 16'((h < 16) && (v < 6)));
        hs_lo += int'(!m_hsync); vs_lo += int'(!m_vsync);
        vid += int'(m_video); fs_n += int'(m_fs);
      end
    end
    chk("mini_hs_low_cycles", 16'(hs_lo), 16'd48);
    chk("mini_vs_low_cycles", 16'(vs_lo), 16'd50);
    chk("mini_video_cycles", 16'(vid), 16'd96);
    chk("mini_frame_starts", 16'(fs_n), 16'd1);
    chk("mini_frame_count", m_fcnt, 16'd1);
    chk("mini_timing_err", 16'(m_err), 16'd0);

    // Hand-computed vectors: mk(hs, vs, vid, px, py, ls, fs, fc, err)
    tab.push_back(row(1, 797, 10, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0)));
    tab.push_back(row(0, 798, 10, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0)));
    tab.push_back(row(0, 799, 10, 1'b1, mk(1, 1, 0, 0, 0, 0, 0, 0, 0)));
    tab.push_back(row(0,   0, 11, 1'b0, mk(1, 1, 1, 0, 11, 1, 0, 0, 0)));
    tab.push_back(row(0,   1, 11, 1'b0, mk(1, 1, 1, 1, 11, 0, 0, 0, 0)));
    tab.push_back(row(1, 299, 20, 1'b0, mk(1, 1, 1, 299, 20, 0, 0, 0, 0)));
    tab.push_back(row(0, 300, 20, 1'b0, mk(1, 1, 1, 300, 20, 0, 0, 0, 0)));
    tab.push_back(row(0, 305, 20, 1'b0, mk(1, 1, 1, 305, 20, 0, 0, 0, 1)));
    tab.push_back(row(0, 306, 20, 1'b0, mk(1, 1, 1, 306, 20, 0, 0, 0, 1)));
    tab.push_back(row(1, 655, 30, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0)));
    tab.push_back(row(0, 656, 30, 1'b0, mk(0, 1, 0, 0, 0, 0, 0, 0, 0)));
    tab.push_back(row(0, 900, 30, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0, 1)));
    tab.push_back(row(0, 900, 30, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0, 1)));
    tab.push_back(row(0,   0, 30, 1'b0, mk(1, 1, 1, 0, 30, 1, 0, 0, 1)));
    tab.push_back(row(0,   1, 30, 1'b0, mk(1, 1, 1, 1, 30, 0, 0, 0, 1)));
    tab.push_back(row(1, 100, 600, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0, 1)));
    tab.push_back(row(0,   0, 600, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0, 1)));
    tab.push_back(row(1, 799, 524, 1'b1, mk(1, 1, 0, 0, 0, 0, 0, 0, 0)));
    tab.push_back(row(0,   0,   0, 1'b0, mk(1, 1, 1, 0, 0, 1, 1, 1, 0)));
    tab.push_back(row(0,   1,   0, 1'b0, mk(1, 1, 1, 1, 0, 0, 0, 1, 0)));
    tab.push_back(row(1,  10, 490, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    tab.push_back(row(0,  11, 490, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    tab.push_back(row(1,  10, 492, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0)));
    tab.push_back(row(1, 751, 100, 1'b0, mk(0, 1, 0, 0, 0, 0, 0, 0, 0)));
    tab.push_back(row(0, 752, 100, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0)));
    tab.push_back(row(1, 639, 479, 1'b0, mk(1, 1, 1, 639, 479, 0, 0, 0, 0)));
    tab.push_back(row(0, 640, 479, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0)));

    foreach (tab[i]) begin
      if (tab[i].rst) do_reset();
      model(tab[i].h, tab[i].v, tab[i].en, junk);
      drive(tab[i].h, tab[i].v, tab[i].en, tab[i].e);
    end

    // Clean lines around the end of the visible area and through V sync
    do_reset();
    run_lines(478, 3, hs_lo, vs_lo, vid);
    do_reset();
    run_lines(488, 5, hs2, vs2, vid2);
    chk("hs_low_cycles", 16'(hs_lo + hs2), 16'(8 * 96));
    chk("vs_low_cycles", 16'(vs_lo + vs2), 16'(2 * 800));
    chk("video_cycles", 16'(vid + vid2), 16'(2 * 640));
    chk("clean_err", 16'(timing_error), 16'd0);

    // Reset landing while both axes are in sync
    do_reset();
    drive_model(16'd699, 16'd491, 1'b0);
    drive_model(16'd700, 16'd491, 1'b0);
    #10 reset_n = 1'b0;
    #1;
    chk("midrst_hsync", 16'(Hsync), 16'd1);
    chk("midrst_vsync", 16'(Vsync), 16'd1);
    chk("midrst_video", 16'(video_on), 16'd0);
    @(posedge clk_25MHz); #1;
    reset_n = 1'b1;
    model_reset();
    drive_model(16'd5, 16'd0, 1'b0);
    chk("post_rst_video", 16'(video_on), 16'd1);
    chk("post_rst_err", 16'(timing_error), 16'd0);

    // Forced frame starts until the frame counter wraps
    do_reset();
    for (int i = 0; i < 65536; i++) drive_model(16'd0, 16'd0, 1'b0);
    chk("wrap_frame_count", frame_count, 16'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
